// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the 28-entry opcode map and the fetch-state enum.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 9;
  localparam int OPC_W   = 5;

  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_XOR  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_XORI = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_BEZ  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_BNZ  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_BLT  = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_BGE  = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_CMP  = 5'b10101;
  localparam logic [OPC_W-1:0] OPC_MOV  = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_INC  = 5'b10111;
  localparam logic [OPC_W-1:0] OPC_JUMP = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_RET  = 5'b11011;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO between fetch and decode; the head is presented straight from storage.
module fetch_skid_fifo #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: PC, RUN/HALTED FSM and decode handoff buffer.
// Define FETCH_PERF_EN to add the perf_issued / perf_stall counters.
module instr_fetch_ctrl #(
  parameter int                PC_W     = cpu_pkg::PC_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(1)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               resume,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_issued,
  output logic [15:0]        perf_stall
`endif
);
  import cpu_pkg::*;

  localparam int ENTRY_W = PC_W + INSTR_W;

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q;
  logic              halted_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              is_halt;
  logic [ENTRY_W-1:0] head;

  // Fullness is judged before any same-cycle pop, so a freed slot only admits a write next cycle.
  assign push    = !redirect && (state_q == FETCH_RUN) && !fifo_full;
  assign pop     = !fifo_empty && id_ready;
  assign is_halt = (opcode_of(rom_instr) == OPC_HALT);

  fetch_skid_fifo #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .din_i   ({pc_q, rom_instr}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (redirect) begin
      state_q  <= FETCH_RUN;
      pc_q     <= redirect_pc;
      halted_q <= 1'b0;
    end else if (push) begin
      pc_q <= pc_q + 1'b1;
      if (is_halt) begin
        state_q  <= FETCH_HALTED;
        halted_q <= 1'b1;
      end
    end else if (state_q == FETCH_HALTED && resume) begin
      state_q  <= FETCH_RUN;
      halted_q <= 1'b0;
    end
  end

  assign pc       = pc_q;
  assign halted   = halted_q;
  assign id_valid = !fifo_empty;
  assign id_pc    = head[ENTRY_W-1 -: PC_W];
  assign id_instr = head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
  logic [15:0] perf_issued_q;
  logic [15:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= 16'd0;
      perf_stall_q  <= 16'd0;
    end else begin
      if (pop) perf_issued_q <= perf_issued_q + 16'd1;
      if (!fifo_empty && !id_ready) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomised scoreboard bench for instr_fetch_ctrl: expected delivery stream vs. monitored pops.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic [8:0]  rom_instr;
  logic        id_valid;
  logic [8:0]  id_instr;
  logic [15:0] id_pc;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        resume = 1'b0;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
  logic [15:0] exp_issued = 16'h0;
  logic [15:0] exp_stall = 16'h0;
`endif

  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0;
  logic [31:0] rom_seed = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [8:0]  instr;
  } item_t;
  item_t exp_q[$];
  item_t mon_e;

  always #5 clk = ~clk;

  // ROM model: pseudo-random program that never contains HALT except at the armed address.
  function automatic logic [8:0] rom_f(input logic [15:0] a, input logic hen,
                                       input logic [15:0] ha, input logic [31:0] sd);
    logic [31:0] h;
    if (hen && a == ha) return {5'b11010, 4'h0};
    h = ({16'h0, a} * 32'h9E3779B1) ^ sd;
    return {5'((h >> 7) % 32'd26), h[3:0]};
  endfunction

  assign rom_instr = rom_f(pc, halt_en, halt_addr, rom_seed);

  instr_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .rom_instr   (rom_instr),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .resume      (resume),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Monitor: pops are sampled on the falling edge and take effect at the next rising edge.
  logic        stall_prev = 1'b0;
  logic        redir_prev = 1'b0;
  logic [15:0] hold_pc = 16'h0;
  logic [8:0]  hold_instr = 9'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
`ifdef FETCH_PERF_EN
      exp_issued = 16'h0;
      exp_stall  = 16'h0;
`endif
    end else begin
      if (stall_prev && !redir_prev) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== hold_pc || id_instr !== hold_instr) begin
          n_fail++;
          $display("FAIL head_hold: got v=%0b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                   id_valid, id_pc, id_instr, hold_pc, hold_instr);
        end
      end
      if (id_valid && id_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got pc=%h instr=%h, required no delivery", id_pc, id_instr);
        end else begin
          mon_e = exp_q.pop_front();
          $display("pop pc=%h instr=%h (expected pc=%h instr=%h)", id_pc, id_instr, mon_e.pc, mon_e.instr);
          if (id_pc !== mon_e.pc || id_instr !== mon_e.instr) begin
            n_fail++;
            $display("FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                     id_pc, id_instr, mon_e.pc, mon_e.instr);
          end
        end
      end
`ifdef FETCH_PERF_EN
      check("perf_issued", 32'(perf_issued), 32'(exp_issued));
      check("perf_stall", 32'(perf_stall), 32'(exp_stall));
      if (id_valid && id_ready) exp_issued = exp_issued + 16'd1;
      if (id_valid && !id_ready) exp_stall = exp_stall + 16'd1;
`endif
      stall_prev = id_valid && !id_ready;
      redir_prev = redirect;
      hold_pc    = id_pc;
      hold_instr = id_instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [15:0] start, input int k);
    for (int i = 0; i < k; i++) begin
      logic [15:0] a;
      a = start + 16'(i);
      exp_q.push_back('{pc: a, instr: rom_f(a, halt_en, halt_addr, rom_seed)});
    end
  endtask

  task automatic drain(input string name, input int budget, input bit always_rdy);
    int c = 0;
    id_ready = always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
      if (exp_q.size() != 0) id_ready = always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    id_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d undelivered after %0d cycles, required 0", name, exp_q.size(), c);
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [15:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect = 1'b0;
    check("redir_flush_valid", 32'(id_valid), 32'd0);
    tick();
    check("redir_tgt_valid", 32'(id_valid), 32'd1);
    check("redir_tgt_pc", 32'(id_pc), 32'(tgt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom_seed = $urandom();
    #12;
    check("rst_pc", 32'(pc), 32'h1);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_id_instr", 32'(id_instr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("cycle0_pc", 32'(pc), 32'h1);

    // Steady state: one instruction per cycle with decode always ready.
    push_run(16'h1, 20);
    drain("stream", 22, 1'b1);
    check("stream_halted", 32'(halted), 32'd0);

    // Random redirects, each taken with the buffer full.
    for (int r = 0; r < 4; r++) begin
      logic [15:0] tgt;
      tgt = 16'($urandom_range(0, 65535));
      repeat (3) tick();
      push_run(tgt, $urandom_range(3, 12));
      do_redirect(tgt);
      drain("rand_redir", 200, 1'b0);
    end

    repeat (3) tick();
    push_run(16'd15, 10);
    do_redirect(16'd15);
    drain("redir15", 200, 1'b0);

    push_run(16'hFFFF, 5);
    do_redirect(16'hFFFF);
    drain("wrap", 200, 1'b0);

    // Halt at 43, idle while halted, then resume at 44.
    halt_en   = 1'b1;
    halt_addr = 16'd43;
    push_run(16'd30, 14);
    do_redirect(16'd30);
    drain("to_halt", 200, 1'b0);
    check("halted_set", 32'(halted), 32'd1);
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_pc_hold", 32'(pc), 32'd44);
      check("halt_no_valid", 32'(id_valid), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
    end
    id_ready = 1'b0;
    push_run(16'd44, 8);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    drain("after_resume", 200, 1'b0);
    halt_en = 1'b0;

    // Redirect lands on the cycle the halt word is on the ROM: halt is not taken.
    halt_en     = 1'b1;
    halt_addr   = 16'd100;
    redirect    = 1'b1;
    redirect_pc = 16'd100;
    tick();
    redirect_pc = 16'd200;
    tick();
    redirect = 1'b0;
    check("redir_halt_halted", 32'(halted), 32'd0);
    push_run(16'd200, 10);
    tick();
    check("redir_halt_halted2", 32'(halted), 32'd0);
    drain("redir_halt", 200, 1'b0);
    halt_en = 1'b0;

    // Asynchronous reset with two entries buffered.
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_id_valid", 32'(id_valid), 32'd0);
    check("midrst_pc", 32'(pc), 32'h1);
    check("midrst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_issued", 32'(perf_issued), 32'd0);
    check("midrst_perf_stall", 32'(perf_stall), 32'd0);
`endif
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;

    // Back-pressure from cycle 1 for 5 cycles, then release.
    push_run(16'h1, 15);
    tick();
    check("bp_valid", 32'(id_valid), 32'd1);
    check("bp_id_pc", 32'(id_pc), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_pc_stall", 32'(pc), 32'h3);
      check("bp_head_pc", 32'(id_pc), 32'h1);
    end
    drain("bp_release", 200, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller for the pipelined CPU. Owns the program counter, drives the combinational instruction ROM, and delivers `{pc, instruction}` pairs to the decode stage through a 2-entry buffer with a valid/ready handshake. Handles branch/jump redirects from execute, stops fetching on the `halt` opcode, and resumes on request.

## Interface
- `PC_W`, 16, program-counter and ROM address width
- `INSTR_W`, 9, instruction width (5-bit opcode + 4-bit operand)
- `RESET_PC`, 1, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc`  out  PC_W  fetch address to the ROM; reset value `RESET_PC`
- `rom_instr`  in  INSTR_W  ROM data for `pc`, combinational, same cycle
- `id_valid`  out  1  head entry valid; reset 0
- `id_instr`  out  INSTR_W  head instruction; reset 0
- `id_pc`  out  PC_W  address of head instruction; reset 0
- `id_ready`  in  1  decode accepts head this cycle
- `redirect`  in  1  one-cycle pulse from execute: flush and refetch
- `redirect_pc`  in  PC_W  redirect target
- `resume`  in  1  leave HALTED and continue fetching
- `halted`  out  1  high while in HALTED; reset 0

## Operation
- States: RUN, HALTED. Reset → RUN.
- RUN, buffer not full, no redirect: write `{pc, rom_instr}` into buffer, `pc <= pc + 1`.
- RUN, buffer full: no write, `pc` held. An entry freed by a same-cycle pop does not admit a write that cycle.
- Fetched opcode (`rom_instr[8:4]`) == HALT (5'b11010): entry written normally, `pc <= pc + 1`, state → HALTED. Halt instruction is delivered to decode like any other.
- HALTED: no fetch, `pc` held; buffer continues to drain. `resume` → RUN next cycle; `pc` unchanged (fetch continues after the halt).
- `redirect` (any state): buffer flushed, `pc <= redirect_pc`, state → RUN. Takes priority over write, halt detection, and `resume`. A pop completing in the same cycle counts as consumed; remaining entries are discarded.
- Pop: `id_valid && id_ready` removes the head. Outputs present the head entry; `id_instr`/`id_pc` are don't-care while `id_valid`=0.
- `pc` arithmetic is modulo 2^PC_W: 0xFFFF + 1 = 0x0000.

## Timing
- ROM to decode latency: 1 cycle. Instruction fetched at edge N appears with `id_valid`=1 after edge N.
- After reset release: `pc`=1 in cycle 0; `id_valid`=1, `id_pc`=1 in cycle 1.
- Steady state with `id_ready`=1: one instruction per cycle.
- Redirect at edge N: `id_valid`=0 in cycle N+1; target instruction valid in cycle N+2.
- Back-pressure: at most 2 instructions are fetched beyond the last accepted one; nothing is lost or duplicated.
- `id_valid` stays high, with head contents stable, until accepted or flushed.
- `rst_n` assertion mid-operation: all outputs return immediately to reset values and the buffer empties.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_issued` (16 bits, counts pops) and `perf_stall` (16 bits, counts cycles with `id_valid && !id_ready`). Both reset to 0 and wrap at 0xFFFF.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`: `PC_W`, `INSTR_W`, `OPC_W`=5, opcode constants for all 28 opcodes (`OPC_HALT`=5'b11010, `OPC_JUMP`=5'b11000, `OPC_BEZ`=5'b10001, …), and a fetch-state enum.
- One sub-module, `fetch_skid_fifo`: 2-entry, parameterised width, with push/pop/flush, `full`, and `empty`. The controller holds the PC, the FSM, and the perf counters.

## Test plan
- Reset, then `id_ready`=1 with a ROM model → `id_pc` sequence 1, 2, 3…, one per cycle; `id_instr` matches ROM; `halted`=0.
- `id_ready`=0 for 5 cycles from cycle 1 → buffer holds pc 1 and 2; `pc` stalls at 3; on release, delivery continues 1, 2, 3 with no gaps or duplicates.
- ROM returns halt at address 43 → `id_instr[8:4]`=11010 with `id_pc`=43; `halted`=1; `pc` stays at 44 for 10 cycles. Then `resume` → next `id_pc`=44.
- Buffer full, then `redirect` with `redirect_pc`=15 → next valid `id_pc`=15; stale entries never appear. Also: `redirect` and halt fetched in the same cycle → `halted` stays 0.
- `redirect_pc`=16'hFFFF → `id_pc` sequence FFFF, 0000, 0001.
- `rst_n` pulsed low mid-stream while 2 entries are buffered → `id_valid`=0 and `pc`=1 immediately; restart from `id_pc`=1. With `FETCH_PERF_EN`: `perf_issued` and `perf_stall` read 0.
